// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Lane steering: extracts and extends load data from a memory word, and
// merges sub-word store data into the previously read word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  mem_size_e         size_i,
    input  logic [1:0]        offset_i,
    input  logic              unsigned_i,
    input  logic [WORD_W-1:0] mem_word_i,
    input  logic [WORD_W-1:0] store_data_i,
    output logic [WORD_W-1:0] load_data_o,
    output logic [WORD_W-1:0] store_word_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Select the addressed lane, then extend for loads or splice for stores.
    always_comb begin
        byte_v       = mem_word_i[{offset_i, 3'b000} +: 8];
        half_v       = mem_word_i[{offset_i[1], 4'b0000} +: 16];
        load_data_o  = mem_word_i;
        store_word_o = store_data_i;
        case (size_i)
            SIZE_BYTE: begin
                load_data_o  = unsigned_i ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
                store_word_o = mem_word_i;
                store_word_o[{offset_i, 3'b000} +: 8] = store_data_i[7:0];
            end
            SIZE_HALF: begin
                // Only addr[1] picks the half; addr[0] is either rejected or ignored upstream.
                load_data_o  = unsigned_i ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
                store_word_o = mem_word_i;
                store_word_o[{offset_i[1], 4'b0000} +: 16] = store_data_i[15:0];
            end
            default: begin
                load_data_o  = mem_word_i;
                store_word_o = store_data_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one byte/half/word request at a time, read-modify-write
// for sub-word stores, single-cycle response pulse.
// Optional macro LSU_MISALIGN_CHECK_EN: misaligned half/word and size 11
// complete with resp_error instead of touching memory. Without it addresses
// are aligned down to the natural boundary and size 11 acts as word.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WORD_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [WORD_W-1:0]     resp_rdata,
    output logic                  resp_error,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_write_enable,
    output logic [WORD_W-1:0]     mem_write_data,
    input  logic [WORD_W-1:0]     mem_read_data
);

    state_e                state_q, state_d;
    mem_size_e             size_q, size_n;
    logic                  write_q;
    logic                  unsigned_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_W-1:0]     wdata_q;
    logic [WORD_W-1:0]     rdata_q;
    logic                  accept;
    logic                  req_err;
    logic [WORD_W-1:0]     load_val;
    logic [WORD_W-1:0]     store_word;

    // Ready is gated by reset so nothing is accepted while reset is held.
    assign req_ready = (state_q == IDLE) && rst;
    assign accept    = req_valid && req_ready;

`ifdef LSU_MISALIGN_CHECK_EN
    assign size_n  = mem_size_e'(req_size);
    assign req_err = (req_size == 2'b11)
                   || ((req_size == SIZE_HALF) && req_addr[0])
                   || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
`else
    // Illegal size falls back to a word access; no error path exists.
    assign size_n  = (req_size == 2'b11) ? SIZE_WORD : mem_size_e'(req_size);
    assign req_err = 1'b0;
`endif

    lsu_lane_align u_align (
        .size_i       (size_q),
        .offset_i     (addr_q[1:0]),
        .unsigned_i   (unsigned_q),
        .mem_word_i   (rdata_q),
        .store_data_i (wdata_q),
        .load_data_o  (load_val),
        .store_word_o (store_word)
    );

    // State register; reset aborts any pending access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Latch the request on accept and capture memory data in READ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            size_q     <= SIZE_BYTE;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            if (accept) begin
                size_q     <= size_n;
                write_q    <= req_write;
                unsigned_q <= req_unsigned;
                err_q      <= req_err;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
            end
            if (state_q == READ) rdata_q <= mem_read_data;
        end
    end

    // Next-state and output decode; memory outputs are quiet outside READ/WRITE.
    always_comb begin
        state_d          = state_q;
        resp_valid       = 1'b0;
        resp_rdata       = '0;
        resp_error       = 1'b0;
        mem_addr         = '0;
        mem_write_enable = 1'b0;
        mem_write_data   = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)                               state_d = RESP;
                    else if (req_write && size_n == SIZE_WORD) state_d = WRITE;
                    else                                       state_d = READ;
                end
            end
            READ: begin
                mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                state_d  = write_q ? WRITE : RESP;
            end
            WRITE: begin
                mem_addr         = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                mem_write_enable = 1'b1;
                mem_write_data   = store_word;
                state_d          = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_error = err_q;
                resp_rdata = (write_q || err_q) ? '0 : load_val;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
